route_dispatch: RTL and testbench

ROUTE_DISPATCH -- requirements
Module: route_dispatch

---
 rtl/route_dispatch_pkg.sv | 36 +++
 rtl/route_dispatch.sv | 110 +++++++++++
 tb/tb_route_dispatch.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/route_dispatch_pkg.sv
// Shared router constants: flit/direction widths, port encodings and dispatch FSM states.
package route_dispatch_pkg;

    localparam int unsigned SIZE     = 8;
    localparam int unsigned BITS_DIR = 3;
    localparam int unsigned NumPorts = 5;

    localparam logic [BITS_DIR-1:0] DirNorth = 3'd0;
    localparam logic [BITS_DIR-1:0] DirSouth = 3'd1;
    localparam logic [BITS_DIR-1:0] DirEast  = 3'd2;
    localparam logic [BITS_DIR-1:0] DirWest  = 3'd3;
    localparam logic [BITS_DIR-1:0] DirLocal = 3'd4;

    typedef enum logic [1:0] {
        StIdle,
        StLookup,
        StReq,
        StRelease
    } state_e;

    // One-hot port select; all-zero marks an invalid direction.
    function automatic logic [NumPorts-1:0] dir_onehot(logic [BITS_DIR-1:0] d);
        logic [NumPorts-1:0] hot;
        hot = '0;
        case (d)
            DirNorth: hot = 5'b00001;
            DirSouth: hot = 5'b00010;
            DirEast:  hot = 5'b00100;
            DirWest:  hot = 5'b01000;
            DirLocal: hot = 5'b10000;
            default:  hot = '0;
        endcase
        return hot;
    endfunction

endpackage

// File: rtl/route_dispatch.sv
// Pops one flit at a time from the shared FIFO, looks up its output port and runs a
// four-phase req/ack handshake with that port's TX transceiver.
module route_dispatch #(
    parameter int          id       = -1,
    parameter int unsigned SIZE     = 8,
    parameter int unsigned BITS_DIR = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empty,
    input  logic [SIZE-1:0]       fifo_data_out,
    output logic                  fifo_read,
    output logic [SIZE-1:0]       table_addr,
    input  logic [BITS_DIR-1:0]   table_data,
    output logic [4:0]            tx_req,
    input  logic [4:0]            tx_ack,
    output logic [5*SIZE-1:0]     tx_data,
    output logic [7:0]            drop_count
);
    import route_dispatch_pkg::*;

    state_e                   state_q;
    logic [SIZE-1:0]          item_q;
    logic [BITS_DIR-1:0]      dir_q;
    logic                     fifo_read_q;
    logic [NumPorts-1:0]      tx_req_q;
    logic [NumPorts*SIZE-1:0] tx_data_q;
    logic [7:0]               drop_q;

    logic [NumPorts-1:0]      lookup_hot;
    logic [NumPorts-1:0]      active_hot;
    logic [NumPorts*SIZE-1:0] lookup_data;
    logic                     lookup_valid;
    logic                     ack_hit;

    always_comb begin
        lookup_hot  = dir_onehot(table_data);
        active_hot  = dir_onehot(dir_q);
        lookup_data = '0;
        for (int k = 0; k < NumPorts; k++) begin
            if (lookup_hot[k]) begin
                lookup_data[SIZE*k +: SIZE] = item_q;
            end
        end
    end

    assign lookup_valid = |lookup_hot;
    // Only the ack of the port currently being served matters.
    assign ack_hit      = |(tx_ack & active_hot);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            item_q      <= '0;
            dir_q       <= '0;
            fifo_read_q <= 1'b0;
            tx_req_q    <= '0;
            tx_data_q   <= '0;
            drop_q      <= '0;
        end else begin
            fifo_read_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (!fifo_empty) begin
                        item_q      <= fifo_data_out;
                        fifo_read_q <= 1'b1;
                        state_q     <= StLookup;
                    end
                end
                StLookup: begin
                    dir_q <= table_data;
                    if (lookup_valid) begin
                        tx_req_q  <= lookup_hot;
                        tx_data_q <= lookup_data;
                        state_q   <= StReq;
`ifndef SYNTHESIS
                        $display("%0t route_dispatch %0d: item %h -> port %0d",
                                 $time, id, item_q, table_data);
`endif
                    end else begin
                        if (drop_q != 8'hFF) begin
                            drop_q <= drop_q + 8'd1;
                        end
                        state_q <= StIdle;
                    end
                end
                StReq: begin
                    if (ack_hit) begin
                        tx_req_q <= '0;
                        state_q  <= StRelease;
                    end
                end
                StRelease: begin
                    if (!ack_hit) begin
                        tx_data_q <= '0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign fifo_read  = fifo_read_q;
    assign table_addr = item_q;
    assign tx_req     = tx_req_q;
    assign tx_data    = tx_data_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_route_dispatch.sv
// Directed bench for route_dispatch: vector table plus hand sequences for handshake corners.
module tb_route_dispatch;

    logic        clk = 1'b0;
    logic        reset;
    logic        fifo_empty;
    logic [7:0]  fifo_data_out;
    logic        fifo_read;
    logic [7:0]  table_addr;
    logic [2:0]  table_data;
    logic [4:0]  tx_req;
    logic [4:0]  tx_ack;
    logic [39:0] tx_data;
    logic [7:0]  drop_count;

    always #5 clk = ~clk;

    route_dispatch #(.id(0), .SIZE(8), .BITS_DIR(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .fifo_empty   (fifo_empty),
        .fifo_data_out(fifo_data_out),
        .fifo_read    (fifo_read),
        .table_addr   (table_addr),
        .table_data   (table_data),
        .tx_req       (tx_req),
        .tx_ack       (tx_ack),
        .tx_data      (tx_data),
        .drop_count   (drop_count)
    );

    // FIFO model (show-ahead)
    logic [7:0] fifo_mem [512];
    int         head = 0;
    int         tail = 0;
    int         reads = 0;
    logic       rd_empty_err = 1'b0;
    assign fifo_empty    = (head == tail);
    assign fifo_data_out = fifo_mem[head % 512];

    always @(posedge clk) begin
        if (fifo_read) begin
            if (head == tail) rd_empty_err <= 1'b1;
            else head <= head + 1;
            reads <= reads + 1;
        end
    end

    // Routing table model
    logic [2:0] route_map [256];
    assign table_data = route_map[table_addr];

    // Ack sources: automatic responder (acks the cycle after req, drops after req falls)
    logic       resp_en = 1'b0;
    logic [4:0] auto_ack = '0;
    logic [4:0] man_ack = '0;
    assign tx_ack = resp_en ? auto_ack : man_ack;

    always @(posedge clk) begin
        if (!resp_en) auto_ack <= '0;
        else if (auto_ack == '0) auto_ack <= tx_req;
        else if (tx_req == '0) auto_ack <= '0;
    end

    // Request monitor
    logic [4:0] prev_req = '0;
    logic [4:0] req_log [64];
    int         log_n = 0;
    logic       overlap = 1'b0;

    always @(negedge clk) begin
        if (tx_req != '0 && prev_req == '0 && log_n < 64) begin
            req_log[log_n] <= tx_req;
            log_n          <= log_n + 1;
        end
        if ($countones(tx_req) > 1) overlap <= 1'b1;
        prev_req <= tx_req;
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] it, input logic [2:0] d);
        route_map[it] = d;
        fifo_mem[tail % 512] = it;
        tail++;
    endtask

    typedef struct {
        logic [7:0]  item;
        logic [2:0]  dir;
        logic [4:0]  req;
        logic [39:0] data;
        int          drop;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [7:0] d0;
        int         r0;
        int         base;
        logic       held;

        for (int i = 0; i < 256; i++) route_map[i] = 3'd7;
        vecs[0] = '{8'h23, 3'd2, 5'b00100, 40'h00_00_23_00_00, 0};
        vecs[1] = '{8'h7F, 3'd6, 5'b00000, 40'h00_00_00_00_00, 1};
        vecs[2] = '{8'hA5, 3'd0, 5'b00001, 40'h00_00_00_00_A5, 0};
        vecs[3] = '{8'h5C, 3'd4, 5'b10000, 40'h5C_00_00_00_00, 0};
        vecs[4] = '{8'h3E, 3'd3, 5'b01000, 40'h00_3E_00_00_00, 0};
        vecs[5] = '{8'h91, 3'd1, 5'b00010, 40'h00_00_00_91_00, 0};
        vecs[6] = '{8'h00, 3'd7, 5'b00000, 40'h00_00_00_00_00, 1};
        vecs[7] = '{8'hFF, 3'd5, 5'b00000, 40'h00_00_00_00_00, 1};

        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req", tx_req, 5'b0);
        check("rst_data", tx_data, 40'h0);
        check("rst_read", fifo_read, 1'b0);
        check("rst_drop", drop_count, 8'd0);
        check("rst_addr", table_addr, 8'd0);
        reset   = 1'b1;
        resp_en = 1'b1;
        @(negedge clk);

        // Single flits, latency two edges from FIFO non-empty to tx_req
        for (int i = 0; i < 8; i++) begin
            d0 = drop_count;
            r0 = reads;
            @(negedge clk);
            push(vecs[i].item, vecs[i].dir);
            repeat (2) @(negedge clk);
            check($sformatf("vec%0d_req", i), tx_req, vecs[i].req);
            check($sformatf("vec%0d_data", i), tx_data, vecs[i].data);
            repeat (8) @(negedge clk);
            check($sformatf("vec%0d_drop", i), int'(drop_count) - int'(d0), vecs[i].drop);
            check($sformatf("vec%0d_reads", i), reads - r0, 1);
        end

        // Back-to-back flits
        base = log_n;
        r0   = reads;
        @(negedge clk);
        push(8'h01, 3'd0);
        push(8'h02, 3'd4);
        push(8'h03, 3'd1);
        for (int c = 0; c < 100 && log_n < base + 3; c++) @(negedge clk);
        repeat (8) @(negedge clk);
        check("b2b_count", log_n - base, 3);
        check("b2b_first", req_log[base], 5'b00001);
        check("b2b_second", req_log[base+1], 5'b10000);
        check("b2b_third", req_log[base+2], 5'b00010);
        check("b2b_reads", reads - r0, 3);
        check("b2b_overlap", overlap, 1'b0);

        // Drop counter saturation
        @(negedge clk);
        for (int i = 0; i < 300; i++) push(8'h7F, 3'd6);
        for (int c = 0; c < 3000 && head != tail; c++) @(negedge clk);
        repeat (4) @(negedge clk);
        check("sat_drained", head == tail, 1'b1);
        check("sat_drop", drop_count, 8'd255);

        // Slow ack with a foreign ack, then ack already high on entry to REQ
        resp_en = 1'b0;
        man_ack = '0;
        r0      = reads;
        @(negedge clk);
        push(8'h44, 3'd3);
        push(8'h45, 3'd1);
        repeat (2) @(negedge clk);
        check("slow_req", tx_req, 5'b01000);
        check("slow_data", tx_data, 40'h00_44_00_00_00);
        man_ack = 5'b00001;
        held    = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (tx_req !== 5'b01000) held = 1'b0;
        end
        check("slow_held", held, 1'b1);
        man_ack = 5'b01000;
        @(negedge clk);
        check("slow_rel_req", tx_req, 5'b0);
        held = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (tx_req !== 5'b0 || tx_data !== 40'h00_44_00_00_00 || table_addr !== 8'h44)
                held = 1'b0;
        end
        check("slow_rel_hold", held, 1'b1);
        man_ack = 5'b00010;
        repeat (3) @(negedge clk);
        check("preack_req", tx_req, 5'b00010);
        check("preack_data", tx_data, 40'h00_00_00_45_00);
        @(negedge clk);
        check("preack_rel", tx_req, 5'b0);
        man_ack = '0;
        repeat (3) @(negedge clk);
        check("slow_reads", reads - r0, 2);

        // Asynchronous reset mid-handshake
        @(negedge clk);
        push(8'h66, 3'd2);
        repeat (2) @(negedge clk);
        check("arst_pre_req", tx_req, 5'b00100);
        #1 reset = 1'b0;
        #1;
        check("arst_req", tx_req, 5'b0);
        check("arst_data", tx_data, 40'h0);
        check("arst_drop", drop_count, 8'd0);
        check("arst_addr", table_addr, 8'd0);
        @(negedge clk);
        reset   = 1'b1;
        resp_en = 1'b1;
        @(negedge clk);
        push(8'h67, 3'd4);
        repeat (2) @(negedge clk);
        check("post_rst_req", tx_req, 5'b10000);
        check("post_rst_data", tx_data, 40'h67_00_00_00_00);
        repeat (8) @(negedge clk);
        check("post_rst_idle", tx_req, 5'b0);
        check("post_rst_drop", drop_count, 8'd0);

        check("no_overlap", overlap, 1'b0);
        check("no_read_empty", rd_empty_err, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
